// File: rtl/branch_predictor_btb_pkg.sv
// Shared types for the BTB: direction counter encoding, table entry layout
// and the saturating counter step.
package bp_pkg;
  // Entry fields are sized for the widest supported PC; narrower configs zero-extend.
  localparam int MAX_XLEN = 64;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef struct packed {
    logic                valid;
    logic [MAX_XLEN-1:0] tag;
    logic [MAX_XLEN-1:0] target;
    ctr_t                ctr;
    logic                is_jump;
  } btb_entry_t;

  function automatic ctr_t sat_ctr_next(input ctr_t c, input logic taken);
    if (taken) return (c == ST)  ? ST  : ctr_t'(c + 2'd1);
    else       return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction
endpackage

// File: rtl/branch_predictor_btb_if.sv
// Fetch lookup / EX resolve bundle between the pipeline (master) and the BTB (slave).
interface branch_predictor_btb_if #(
  parameter int XLEN   = 32,
  parameter int PERF_W = 32
);
  logic [XLEN-1:0]   if_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [XLEN-1:0]   pred_target;
  logic              upd_valid;
  logic [XLEN-1:0]   upd_pc;
  logic              upd_is_jump;
  logic              upd_taken;
  logic [XLEN-1:0]   upd_target;
  logic              upd_pred_taken;
  logic [XLEN-1:0]   upd_pred_target;
  logic              inval_all;
  logic              mispredict;
  logic [XLEN-1:0]   redirect_pc;
  logic [PERF_W-1:0] perf_lookups;
  logic [PERF_W-1:0] perf_mispred;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, inval_all,
    input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           perf_lookups, perf_mispred
  );
  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_is_jump, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, inval_all,
    output pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
           perf_lookups, perf_mispred
  );
endinterface

// File: rtl/branch_predictor_btb_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module bp_sat_counter #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                count <= '0;
    else if (inc && !(&count)) count <= count + PERF_W'(1);
  end
endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit direction counters: 0-cycle fetch lookup,
// EX-stage training and mispredict redirect.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 64,
  parameter int PRED_MODE = 1,
  parameter int PERF_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_predictor_btb_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam bit DYN   = (PRED_MODE != 0);

  btb_entry_t          tbl [ENTRIES];
  btb_entry_t          lk_e, up_e;
  logic [IDX_W-1:0]    lk_idx, up_idx;
  logic [MAX_XLEN-1:0] lk_tag, up_tag, up_tgt;
  logic                up_hit;
  logic                unused_hi;

  assign lk_idx = bus.if_pc[IDX_W+1:2];
  assign up_idx = bus.upd_pc[IDX_W+1:2];
  assign lk_tag = {{(MAX_XLEN-TAG_W){1'b0}}, bus.if_pc[XLEN-1:IDX_W+2]};
  assign up_tag = {{(MAX_XLEN-TAG_W){1'b0}}, bus.upd_pc[XLEN-1:IDX_W+2]};
  assign up_tgt = {{(MAX_XLEN-XLEN){1'b0}}, bus.upd_target};
  assign lk_e   = tbl[lk_idx];
  assign up_e   = tbl[up_idx];
  assign up_hit = up_e.valid && (up_e.tag == up_tag);

  // Lookup reads registered state only: a same-cycle update is not bypassed.
  assign bus.pred_hit    = lk_e.valid && (lk_e.tag == lk_tag);
  assign bus.pred_taken  = DYN && bus.pred_hit && (lk_e.is_jump || lk_e.ctr[1]);
  assign bus.pred_target = bus.pred_taken ? lk_e.target[XLEN-1:0] : bus.if_pc + XLEN'(4);

  assign bus.mispredict  = bus.upd_valid &&
                           ((bus.upd_taken != bus.upd_pred_taken) ||
                            (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
  assign bus.redirect_pc = bus.upd_taken ? bus.upd_target : bus.upd_pc + XLEN'(4);

  assign unused_hi = ^{lk_e.target >> XLEN, up_e.target, up_e.is_jump};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT, is_jump: 1'b0};
    end else if (bus.inval_all) begin
      // Invalidate wins over any concurrent training.
      for (int i = 0; i < ENTRIES; i++) tbl[i].valid <= 1'b0;
    end else if (bus.upd_valid) begin
      if (up_hit) begin
        tbl[up_idx].is_jump <= bus.upd_is_jump;
        if (bus.upd_is_jump) begin
          tbl[up_idx].target <= up_tgt;
          tbl[up_idx].ctr    <= ST;
        end else begin
          tbl[up_idx].ctr <= sat_ctr_next(up_e.ctr, bus.upd_taken);
          if (bus.upd_taken) tbl[up_idx].target <= up_tgt;
        end
      end else if (bus.upd_taken) begin
        tbl[up_idx] <= '{valid: 1'b1, tag: up_tag, target: up_tgt,
                         ctr: (bus.upd_is_jump ? ST : WT), is_jump: bus.upd_is_jump};
      end
    end
  end

  bp_sat_counter #(.PERF_W(PERF_W)) u_lookups (
    .clk(clk), .reset(reset), .inc(bus.upd_valid), .count(bus.perf_lookups)
  );
  bp_sat_counter #(.PERF_W(PERF_W)) u_mispred (
    .clk(clk), .reset(reset), .inc(bus.mispredict), .count(bus.perf_mispred)
  );
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: a dynamic instance and a static instance with
// 3-bit perf counters share one stimulus stream.
module tb_branch_predictor_btb;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] t_if_pc, t_upc, t_utgt, t_uptgt;
  logic        t_uv, t_uj, t_ut, t_upt, t_inv;

  branch_predictor_btb_if #(.XLEN(32), .PERF_W(32)) bi0 ();
  branch_predictor_btb_if #(.XLEN(32), .PERF_W(3))  bi1 ();

  always_comb begin
    bi0.if_pc = t_if_pc; bi0.upd_valid = t_uv; bi0.upd_pc = t_upc; bi0.upd_is_jump = t_uj;
    bi0.upd_taken = t_ut; bi0.upd_target = t_utgt; bi0.upd_pred_taken = t_upt;
    bi0.upd_pred_target = t_uptgt; bi0.inval_all = t_inv;
    bi1.if_pc = t_if_pc; bi1.upd_valid = t_uv; bi1.upd_pc = t_upc; bi1.upd_is_jump = t_uj;
    bi1.upd_taken = t_ut; bi1.upd_target = t_utgt; bi1.upd_pred_taken = t_upt;
    bi1.upd_pred_target = t_uptgt; bi1.inval_all = t_inv;
  end

  branch_predictor_btb #(.XLEN(32), .ENTRIES(64), .PRED_MODE(1), .PERF_W(32)) dut0 (
    .clk(clk), .reset(reset), .bus(bi0));
  branch_predictor_btb #(.XLEN(32), .ENTRIES(64), .PRED_MODE(0), .PERF_W(3)) dut1 (
    .clk(clk), .reset(reset), .bus(bi1));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ipc, input logic v, input logic [31:0] pc,
                       input logic j, input logic t, input logic [31:0] tg,
                       input logic pt, input logic [31:0] ptg, input logic inv);
    t_if_pc = ipc; t_uv = v; t_upc = pc; t_uj = j; t_ut = t; t_utgt = tg;
    t_upt = pt; t_uptgt = ptg; t_inv = inv;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] if_pc; logic uv; logic [31:0] upc; logic uj, ut; logic [31:0] utgt;
    logic upt; logic [31:0] uptgt; logic inv;
    logic e_hit, e_tk; logic [31:0] e_tgt; logic e_mp; logic [31:0] e_rd; int e_lk, e_mpc;
  } vec_t;
  vec_t vt[$];

  task automatic v(input logic [31:0] ipc, input logic uv, input logic [31:0] upc,
                   input logic uj, input logic ut, input logic [31:0] utgt, input logic upt,
                   input logic [31:0] uptgt, input logic inv, input logic e_hit,
                   input logic e_tk, input logic [31:0] e_tgt, input logic e_mp,
                   input logic [31:0] e_rd, input int e_lk, input int e_mpc);
    vec_t r;
    r.if_pc = ipc; r.uv = uv; r.upc = upc; r.uj = uj; r.ut = ut; r.utgt = utgt;
    r.upt = upt; r.uptgt = uptgt; r.inv = inv; r.e_hit = e_hit; r.e_tk = e_tk;
    r.e_tgt = e_tgt; r.e_mp = e_mp; r.e_rd = e_rd; r.e_lk = e_lk; r.e_mpc = e_mpc;
    vt.push_back(r);
  endtask

  // ---------------- reference model ----------------
  bit          m_valid [64];
  int unsigned m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  bit          m_jmp   [64];
  int          m_lk0, m_mp0, m_lk1, m_mp1;

  function automatic void m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1; m_jmp[i] = 0;
    end
    m_lk0 = 0; m_mp0 = 0; m_lk1 = 0; m_mp1 = 0;
  endfunction

  function automatic void m_look(input logic [31:0] pc, input bit dyn, output bit hit,
                                 output bit tk, output logic [31:0] tgt);
    int i;
    i   = int'((pc / 4) % 64);
    hit = m_valid[i] && (m_tag[i] == pc / 256);
    tk  = dyn && hit && (m_jmp[i] || m_ctr[i] >= 2);
    tgt = tk ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void m_train(input bit mp);
    int  i;
    bit  hit;
    i   = int'((t_upc / 4) % 64);
    hit = m_valid[i] && (m_tag[i] == t_upc / 256);
    if (t_uv) begin
      m_lk0++; m_lk1 = (m_lk1 < 7) ? m_lk1 + 1 : 7;
    end
    if (mp) begin
      m_mp0++; m_mp1 = (m_mp1 < 7) ? m_mp1 + 1 : 7;
    end
    if (t_inv) begin
      for (int k = 0; k < 64; k++) m_valid[k] = 0;
    end else if (t_uv && hit) begin
      m_jmp[i] = t_uj;
      if (t_uj) begin m_tgt[i] = t_utgt; m_ctr[i] = 3; end
      else begin
        m_ctr[i] = t_ut ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                        : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
        if (t_ut) m_tgt[i] = t_utgt;
      end
    end else if (t_uv && t_ut) begin
      m_valid[i] = 1; m_tag[i] = t_upc / 256; m_tgt[i] = t_utgt; m_jmp[i] = t_uj;
      m_ctr[i] = t_uj ? 3 : 2;
    end
  endfunction

  function automatic logic [31:0] rpc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC | $urandom_range(0, 3);
    return ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
  endfunction

  initial begin
    bit          h, tk, ph, ptk;
    logic [31:0] tg, ptg;
    bit          emp;
    logic [31:0] erd;

    drive(32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
    //  if_pc  uv upc   j t tgt   pt ptgt  inv | hit tk tgt  mp redir lk mp
    v(32'h40,  0, 0,    0,0,0,    0,0,     0,    0,0,32'h44, 0,32'h4,   0,0);
    v(32'h40,  1,32'h40,0,1,32'h100,0,32'h44,0,  0,0,32'h44, 1,32'h100, 0,0);
    v(32'h40,  0, 0,    0,0,0,    0,0,     0,    1,1,32'h100,0,32'h4,   1,1);
    v(32'h40,  1,32'h40,0,0,0,    1,32'h100,0,   1,1,32'h100,1,32'h44,  1,1);
    v(32'h40,  1,32'h40,0,0,0,    0,32'h44,0,    1,0,32'h44, 0,32'h44,  2,2);
    v(32'h40,  1,32'h40,0,0,0,    0,32'h44,0,    1,0,32'h44, 0,32'h44,  3,2);
    v(32'h40,  0, 0,    0,0,0,    0,0,     0,    1,0,32'h44, 0,32'h4,   4,2);
    v(32'h40,  1,32'h40,0,1,32'h100,0,32'h44,0,  1,0,32'h44, 1,32'h100, 4,2);
    v(32'h140, 1,32'h140,0,1,32'h200,0,32'h144,0,0,0,32'h144,1,32'h200, 5,3);
    v(32'h40,  0, 0,    0,0,0,    0,0,     0,    0,0,32'h44, 0,32'h4,   6,4);
    v(32'h140, 0, 0,    0,0,0,    0,0,     0,    1,1,32'h200,0,32'h4,   6,4);
    v(32'h80,  1,32'h80,1,1,32'h300,0,32'h84,0,  0,0,32'h84, 1,32'h300, 6,4);
    v(32'h80,  0, 0,    0,0,0,    0,0,     0,    1,1,32'h300,0,32'h4,   7,5);
    v(32'h80,  1,32'h80,1,1,32'h300,1,32'h304,0, 1,1,32'h300,1,32'h300, 7,5);
    v(32'h140, 1,32'h40,0,1,32'h100,0,32'h44,1,  1,1,32'h200,1,32'h100, 8,6);
    v(32'h40,  0, 0,    0,0,0,    0,0,     0,    0,0,32'h44, 0,32'h4,   9,7);
    v(32'h40,  1,32'h40,0,0,0,    1,32'h100,0,   0,0,32'h44, 1,32'h44,  9,7);
    v(32'h40,  0, 0,    0,0,0,    0,0,     0,    0,0,32'h44, 0,32'h4,   10,8);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    foreach (vt[k]) begin
      drive(vt[k].if_pc, vt[k].uv, vt[k].upc, vt[k].uj, vt[k].ut, vt[k].utgt,
            vt[k].upt, vt[k].uptgt, vt[k].inv);
      #1;
      chk($sformatf("v%0d hit", k),    bi0.pred_hit,     vt[k].e_hit);
      chk($sformatf("v%0d taken", k),  bi0.pred_taken,   vt[k].e_tk);
      chk($sformatf("v%0d target", k), bi0.pred_target,  vt[k].e_tgt);
      chk($sformatf("v%0d mispred", k),bi0.mispredict,   vt[k].e_mp);
      chk($sformatf("v%0d redirect", k), bi0.redirect_pc, vt[k].e_rd);
      chk($sformatf("v%0d perf_lk", k), bi0.perf_lookups, 64'(vt[k].e_lk));
      chk($sformatf("v%0d perf_mp", k), bi0.perf_mispred, 64'(vt[k].e_mpc));
      chk($sformatf("v%0d s.hit", k),   bi1.pred_hit,     vt[k].e_hit);
      chk($sformatf("v%0d s.taken", k), bi1.pred_taken,   1'b0);
      chk($sformatf("v%0d s.target", k), bi1.pred_target, vt[k].if_pc + 32'd4);
      chk($sformatf("v%0d s.mispred", k), bi1.mispredict, vt[k].e_mp);
      chk($sformatf("v%0d s.perf_lk", k), bi1.perf_lookups, 64'((vt[k].e_lk > 7) ? 7 : vt[k].e_lk));
      chk($sformatf("v%0d s.perf_mp", k), bi1.perf_mispred, 64'((vt[k].e_mpc > 7) ? 7 : vt[k].e_mpc));
      @(posedge clk); @(negedge clk);
    end

    // ---------------- randomized run against the model ----------------
    reset = 1'b1; m_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      logic [31:0] upc;
      bit          uj, ut;
      upc = rpc();
      uj  = ($urandom_range(0, 3) == 0);
      ut  = uj ? 1'b1 : 1'($urandom_range(0, 1));
      m_look(upc, 1, ph, ptk, ptg);
      if ($urandom_range(0, 3) == 0) begin
        ptk = 1'($urandom_range(0, 1)); ptg = $urandom & 32'hFFFF_FFFC;
      end
      drive(rpc(), 1'($urandom_range(0, 2) != 0), upc, uj, ut,
            ($urandom_range(0, 1) != 0) ? ptg : ($urandom & 32'hFFFF_FFFC),
            ptk, ptg, 1'($urandom_range(0, 29) == 0));
      #1;
      emp = t_uv && ((t_ut != t_upt) || (t_ut && t_utgt != t_uptgt));
      erd = t_ut ? t_utgt : t_upc + 32'd4;
      m_look(t_if_pc, 1, h, tk, tg);
      chk($sformatf("r%0d hit", c),      bi0.pred_hit,    h);
      chk($sformatf("r%0d taken", c),    bi0.pred_taken,  tk);
      chk($sformatf("r%0d target", c),   bi0.pred_target, tg);
      chk($sformatf("r%0d mispred", c),  bi0.mispredict,  emp);
      chk($sformatf("r%0d redirect", c), bi0.redirect_pc, erd);
      chk($sformatf("r%0d perf_lk", c),  bi0.perf_lookups, 64'(m_lk0));
      chk($sformatf("r%0d perf_mp", c),  bi0.perf_mispred, 64'(m_mp0));
      m_look(t_if_pc, 0, h, tk, tg);
      chk($sformatf("r%0d s.hit", c),    bi1.pred_hit,    h);
      chk($sformatf("r%0d s.taken", c),  bi1.pred_taken,  tk);
      chk($sformatf("r%0d s.target", c), bi1.pred_target, tg);
      chk($sformatf("r%0d s.perf_lk", c), bi1.perf_lookups, 64'(m_lk1));
      chk($sformatf("r%0d s.perf_mp", c), bi1.perf_mispred, 64'(m_mp1));
      @(posedge clk);
      m_train(emp);
      @(negedge clk);
    end

    // ---------------- asynchronous reset mid-cycle ----------------
    drive(32'h40, 1, 32'h40, 0, 1, 32'h100, 0, 32'h44, 0);
    @(posedge clk); @(negedge clk);
    drive(32'h40, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("arst pre hit", bi0.pred_hit, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("arst hit",     bi0.pred_hit,     1'b0);
    chk("arst target",  bi0.pred_target,  32'h44);
    chk("arst perf_lk", bi0.perf_lookups, 32'h0);
    chk("arst perf_mp", bi0.perf_mispred, 32'h0);
    chk("arst s.perf_lk", bi1.perf_lookups, 3'h0);
    // An update presented while reset is held must not land.
    drive(32'h80, 1, 32'h80, 1, 1, 32'h300, 0, 32'h84, 0);
    @(posedge clk); @(negedge clk);
    drive(32'h80, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("arst held hit", bi0.pred_hit, 1'b0);
    chk("arst held perf", bi0.perf_lookups, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- The IF stage looks up the fetch PC combinationally and gets a predicted next-PC. EX reports the resolved branch/jump outcome, which updates the table and produces a mispredict redirect.
- Generalises the fixed "predict not-taken, flush on EX taken" policy to a parametrised dynamic predictor. The static mode is kept for comparison.

Parameters:
- XLEN, 32, PC/target width.
- ENTRIES, 64, table depth; power of two, at least 2.
- PRED_MODE, 1, 0 = static not-taken (outputs forced not-taken, table still trains); 1 = dynamic.
- PERF_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- if_pc  in  XLEN  fetch PC to look up
- pred_hit  out  1  valid tag match for if_pc
- pred_taken  out  1  predict redirect this fetch
- pred_target  out  XLEN  predicted next PC (if_pc+4 when not taken)
- upd_valid  in  1  EX has a resolved control-flow instruction this cycle
- upd_pc  in  XLEN  PC of the resolved instruction
- upd_is_jump  in  1  1 = unconditional (j/jal/jr), 0 = conditional branch
- upd_taken  in  1  actual outcome
- upd_target  in  XLEN  actual target
- upd_pred_taken  in  1  prediction carried down the pipe with the instruction
- upd_pred_target  in  XLEN  predicted target carried down the pipe
- inval_all  in  1  synchronous clear of every valid bit
- mispredict  out  1  flush IF/ID and ID/EX, redirect PC
- redirect_pc  out  XLEN  correct next PC when mispredict=1
- perf_lookups  out  PERF_W  count of resolved upd_valid events
- perf_mispred  out  PERF_W  count of mispredicts

Behaviour:
- Indexing:
  - IDX_W = log2(ENTRIES); idx = pc[IDX_W+1:2].
  - TAG_W = XLEN-IDX_W-2; tag = pc[XLEN-1:IDX_W+2].
  - pc[1:0] is ignored.
- Entry fields: valid, tag, target[XLEN], ctr[1:0], is_jump.
- Lookup (combinational from registered state, 0-cycle latency):
  - hit = valid && tag match.
  - pred_taken = PRED_MODE && hit && (is_jump || ctr[1]).
  - pred_target = pred_taken ? target : if_pc+4 (mod 2^XLEN).
- Reset: all valid=0, ctr=2'b01, tag/target=0, perf counters=0; outputs are therefore pred_hit=0, pred_taken=0, mispredict=0.
- Update, applied on the rising edge when upd_valid=1:
  - Hit, conditional branch: ctr saturating +1 if taken, -1 if not (11 stays 11, 00 stays 00). When taken, target←upd_target. is_jump←upd_is_jump.
  - Hit, jump: target←upd_target; ctr←2'b11.
  - Miss, taken: allocate, overwriting the slot. valid=1, tag, target, is_jump set; ctr=2'b10 for a conditional branch, 2'b11 for a jump.
  - Miss, not taken: no change.
- Lookup and update to the same index in one cycle: the lookup sees the old contents; there is no write-through bypass.
- mispredict (combinational) = upd_valid && ((upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target)).
- redirect_pc = upd_taken ? upd_target : upd_pc+4. redirect_pc is don't-care when mispredict=0 but is driven deterministically.
- inval_all: clears all valid bits on the edge. If an update is also present that cycle, inval_all wins; no allocation happens that cycle. mispredict is still reported.
- Perf counters:
  - perf_lookups +1 per upd_valid; perf_mispred +1 per mispredict.
  - Both saturate at all-ones; no wrap.
- Reset asserted mid-operation clears everything immediately and asynchronously; no partial update completes.
- Stall handling is external: a stalled IF repeats if_pc and the outputs stay consistent. The update path must only be pulsed once per resolved instruction.

Decomposition:
- Package bp_pkg:
  - ctr_t (2-bit) with constants SNT=00, WNT=01, WT=10, ST=11.
  - btb_entry_t struct (valid, tag, target, ctr, is_jump).
  - Function sat_ctr_next(ctr, taken).
- Sub-module bp_sat_counter: a parameterised saturating perf counter (width PERF_W, inc input), instantiated twice.

Test Plan:
1. Reset, then if_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44, perf counters 0.
2. Update pc=0x40, cond, taken, target=0x100, pred_taken=0 -> mispredict=1, redirect_pc=0x100. Next cycle if_pc=0x40 -> hit=1, pred_taken=1, pred_target=0x100.
3. Three not-taken updates at 0x40, each with correct upd_pred -> ctr 10→01→00→00 (saturates). Lookup pred_taken=0. The second update is mispredict=0, redirect_pc=0x44.
4. ENTRIES=64: allocate 0x40 (taken to 0x100), then allocate 0x140 (same idx, taken to 0x200) -> lookup 0x40 misses, lookup 0x140 predicts 0x200.
5. Jump at 0x80 to 0x300, then the same jump with a wrong carried target 0x304 -> the second event has mispredict=1, redirect_pc=0x300. PRED_MODE=0 -> pred_taken always 0 on the same sequence.
6. inval_all together with a taken update at 0x40 -> next-cycle lookup misses, perf_lookups incremented. Force perf_mispred to its maximum value, then mispredict -> value unchanged (saturation).
